// File: rtl/sample_sched_if.sv
// Handshake and sample-counter bundle for sample_sched: two requesters, control, and counter link.
interface sample_sched_if;
  logic       start;
  logic       stop;
  logic       req0_valid;
  logic       req1_valid;
  logic [7:0] req0_data;
  logic [7:0] req1_data;
  logic       req0_ready;
  logic       req1_ready;
  logic [7:0] smp_data_in;
  logic       smp_enable;
  logic [9:0] smp_count;
  logic       busy;
  logic       done;
  logic [9:0] final_count;
  logic [15:0] vec_total;

  modport master (
    output start, stop, req0_valid, req1_valid, req0_data, req1_data, smp_count,
    input  req0_ready, req1_ready, smp_data_in, smp_enable, busy, done, final_count, vec_total
  );

  modport slave (
    input  start, stop, req0_valid, req1_valid, req0_data, req1_data, smp_count,
    output req0_ready, req1_ready, smp_data_in, smp_enable, busy, done, final_count, vec_total
  );
endinterface

// File: rtl/sample_sched.sv
// Session scheduler: settles, then round-robin accepts vectors from two requesters into a
// sample counter until MAX_VECTORS or stop, drains two cycles and reports the final count.
module sample_sched #(
  parameter int SETTLE_CYCLES = 10,
  parameter int MAX_VECTORS   = 3
) (
  input logic           sim_clk,
  input logic           reset,
  sample_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DRAIN} state_t;

  localparam logic [15:0] MAX_VEC     = 16'(MAX_VECTORS);
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES);

  state_t      state_reg;
  logic [31:0] settle_cnt_reg;
  logic        drain_cnt_reg;
  logic        last_grant_reg;
  logic        smp_enable_reg;
  logic [7:0]  smp_data_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [9:0]  final_count_reg;
  logic [15:0] vec_total_reg;

  logic        grant;
  logic        run_ok;
  logic        ready0;
  logic        ready1;
  logic        xfer;
  logic [7:0]  grant_data;
  logic [15:0] vec_next;

  // Grant favours whichever requester did not win the previous transfer.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_reg;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
    run_ok     = (state_reg == RUN) && !bus.stop;
    ready0     = run_ok && !grant && bus.req0_valid;
    ready1     = run_ok && grant && bus.req1_valid;
    xfer       = ready0 || ready1;
    grant_data = grant ? bus.req1_data : bus.req0_data;
    vec_next   = (vec_total_reg == 16'hFFFF) ? vec_total_reg : vec_total_reg + 16'd1;
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.smp_enable  = smp_enable_reg;
  assign bus.smp_data_in = smp_data_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.final_count = final_count_reg;
  assign bus.vec_total   = vec_total_reg;

  always_ff @(posedge sim_clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      settle_cnt_reg  <= 32'd0;
      drain_cnt_reg   <= 1'b0;
      last_grant_reg  <= 1'b1;
      smp_enable_reg  <= 1'b0;
      smp_data_reg    <= 8'd0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      final_count_reg <= 10'd0;
      vec_total_reg   <= 16'd0;
    end else begin
      smp_enable_reg <= 1'b0;
      done_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            vec_total_reg <= 16'd0;
            busy_reg      <= 1'b1;
            if (SETTLE_CYCLES == 0) begin
              state_reg      <= RUN;
              settle_cnt_reg <= 32'd0;
            end else begin
              state_reg      <= SETTLE;
              settle_cnt_reg <= SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt_reg <= 32'd1) begin
            state_reg      <= RUN;
            settle_cnt_reg <= 32'd0;
          end else begin
            settle_cnt_reg <= settle_cnt_reg - 32'd1;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= 1'b0;
          end else if (xfer) begin
            smp_enable_reg <= 1'b1;
            smp_data_reg   <= grant_data;
            vec_total_reg  <= vec_next;
            last_grant_reg <= grant;
            if (vec_next == MAX_VEC) begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Second drain cycle: the counter has absorbed the last enable by now.
          if (drain_cnt_reg) begin
            state_reg       <= IDLE;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b1;
            final_count_reg <= bus.smp_count;
          end else begin
            drain_cnt_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_sched.sv
// Randomized self-checking bench for sample_sched: two instances (default, and zero-settle/4-vector)
// checked cycle by cycle against a transaction-level session model.
module tb_sample_sched;

  logic sim_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 sim_clk = ~sim_clk;

  logic       start0 = 1'b0, start1 = 1'b0, stop_s = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'd0, d1 = 8'd0;
  logic [9:0] cnt0, cnt1;
  logic       sel = 1'b0;

  sample_sched_if bus0 ();
  sample_sched_if bus1 ();

  assign bus0.start = start0;   assign bus1.start = start1;
  assign bus0.stop = stop_s;    assign bus1.stop = stop_s;
  assign bus0.req0_valid = v0;  assign bus1.req0_valid = v0;
  assign bus0.req1_valid = v1;  assign bus1.req1_valid = v1;
  assign bus0.req0_data = d0;   assign bus1.req0_data = d0;
  assign bus0.req1_data = d1;   assign bus1.req1_data = d1;
  assign bus0.smp_count = cnt0; assign bus1.smp_count = cnt1;

  sample_sched dut0 (.sim_clk(sim_clk), .reset(reset), .bus(bus0));
  sample_sched #(.SETTLE_CYCLES(0), .MAX_VECTORS(4)) dut1 (.sim_clk(sim_clk), .reset(reset), .bus(bus1));

  // Sample counters attached to each instance.
  always @(posedge sim_clk or negedge reset) begin
    if (!reset) begin
      cnt0 <= 10'd0;
      cnt1 <= 10'd0;
    end else begin
      if (bus0.smp_enable) cnt0 <= cnt0 + 10'd1;
      if (bus1.smp_enable) cnt1 <= cnt1 + 10'd1;
    end
  end

  logic        o_r0, o_r1, o_en, o_busy, o_done;
  logic [7:0]  o_sd;
  logic [9:0]  o_fc;
  logic [15:0] o_vt;
  always_comb begin
    o_r0 = sel ? bus1.req0_ready : bus0.req0_ready;
    o_r1 = sel ? bus1.req1_ready : bus0.req1_ready;
    o_en = sel ? bus1.smp_enable : bus0.smp_enable;
    o_sd = sel ? bus1.smp_data_in : bus0.smp_data_in;
    o_busy = sel ? bus1.busy : bus0.busy;
    o_done = sel ? bus1.done : bus0.done;
    o_fc = sel ? bus1.final_count : bus0.final_count;
    o_vt = sel ? bus1.vec_total : bus0.vec_total;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state per instance
  int         m_last[2];
  logic [7:0] m_sdata[2];
  int         m_total[2];

  // Per-RUN-cycle stimulus for the next session
  bit         va0[64], va1[64], sa[64];
  logic [7:0] da0[64], da1[64];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_last[i] = 1;
      m_sdata[i] = 8'd0;
      m_total[i] = 0;
    end
  endtask

  task automatic set_start(input logic s);
    if (sel) start1 = s; else start0 = s;
  endtask

  task automatic run_session(input string tag);
    int settle, maxv, cnt, g, end_c, k, idx;
    bit ended, in_run, xfer, er0, er1, exp_busy, exp_done;
    settle = sel ? 0 : 10;
    maxv = sel ? 4 : 3;
    idx = sel ? 1 : 0;
    cnt = 0; ended = 0; end_c = 0;
    for (int c = 0; c < settle + 90; c++) begin
      @(negedge sim_clk);
      in_run = !ended && (c >= settle + 1);
      k = c - settle - 1;
      if (in_run && k >= 64) begin
        checks++; errors++;
        $display("FAIL %s timeout: got no session end, required end within 64 RUN cycles", tag);
        set_start(1'b0);
        return;
      end
      set_start((c == 0) || (c > 0 && (!ended || c <= end_c + 2) && $urandom_range(0, 3) == 0));
      if (in_run) begin
        v0 = va0[k]; v1 = va1[k]; d0 = da0[k]; d1 = da1[k]; stop_s = sa[k];
      end else begin
        v0 = 1'($urandom); v1 = 1'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
        stop_s = 1'($urandom);
      end
      g = -1;
      if (in_run && !stop_s) begin
        if (v0 && v1) g = (m_last[idx] == 0) ? 1 : 0;
        else if (v0) g = 0;
        else if (v1) g = 1;
      end
      er0 = (g == 0);
      er1 = (g == 1);
      #1;
      checks++;
      if (o_r0 !== er0 || o_r1 !== er1) begin
        errors++;
        $display("FAIL %s readys cyc %0d: got r0=%b r1=%b, required r0=%b r1=%b", tag, c, o_r0, o_r1, er0, er1);
      end
      @(posedge sim_clk);
      #1;
      xfer = (g >= 0);
      if (xfer) begin
        cnt++;
        m_last[idx] = g;
        m_sdata[idx] = (g == 1) ? d1 : d0;
        m_total[idx]++;
        if (cnt == maxv) begin ended = 1; end_c = c; end
      end else if (in_run && stop_s) begin
        ended = 1; end_c = c;
      end
      exp_busy = !(ended && c + 1 >= end_c + 3);
      exp_done = ended && (c + 1 == end_c + 3);
      checks++;
      if (o_en !== xfer || o_sd !== m_sdata[idx] || o_vt !== 16'(cnt) || o_busy !== exp_busy || o_done !== exp_done) begin
        errors++;
        $display("FAIL %s outputs cyc %0d: got en=%b sd=%h vt=%0d busy=%b done=%b, required en=%b sd=%h vt=%0d busy=%b done=%b",
                 tag, c + 1, o_en, o_sd, o_vt, o_busy, o_done, xfer, m_sdata[idx], cnt, exp_busy, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (o_fc !== 10'(m_total[idx])) begin
          errors++;
          $display("FAIL %s final_count: got %0d, required %0d", tag, o_fc, m_total[idx] % 1024);
        end
        @(negedge sim_clk);
        set_start(1'b0);
        stop_s = 1'($urandom);
        @(posedge sim_clk);
        #1;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_vt !== 16'(cnt)) begin
          errors++;
          $display("FAIL %s idle after done: got done=%b busy=%b vt=%0d, required 0 0 %0d", tag, o_done, o_busy, o_vt, cnt);
        end
        $display("session %s: %0d vectors, final_count %0d", tag, cnt, o_fc);
        return;
      end
    end
    checks++; errors++;
    set_start(1'b0);
    $display("FAIL %s timeout: got no done pulse, required one", tag);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (o_r0 !== 1'b0 || o_r1 !== 1'b0 || o_en !== 1'b0 || o_sd !== 8'd0 || o_busy !== 1'b0 ||
        o_done !== 1'b0 || o_fc !== 10'd0 || o_vt !== 16'd0) begin
      errors++;
      $display("FAIL %s: got r0=%b r1=%b en=%b sd=%h busy=%b done=%b fc=%0d vt=%0d, required all 0",
               tag, o_r0, o_r1, o_en, o_sd, o_busy, o_done, o_fc, o_vt);
    end
  endtask

  task automatic test_reset();
    v0 = 1'b1; v1 = 1'b1;
    #2;
    sel = 1'b0; #1; check_all_zero("reset_dut0");
    sel = 1'b1; #1; check_all_zero("reset_dut1");
    sel = 1'b0;
    @(negedge sim_clk);
    reset = 1'b1;
    start0 = 1'b1;
    @(posedge sim_clk);
    #1;
    checks++;
    if (o_busy !== 1'b1 || o_r0 !== 1'b0) begin
      errors++;
      $display("FAIL first_start: got busy=%b r0=%b, required busy=1 r0=0", o_busy, o_r0);
    end
    @(negedge sim_clk);
    start0 = 1'b0;
    reset = 1'b0;
    #1;
    check_all_zero("reset_in_settle");
    @(negedge sim_clk);
    reset = 1'b1;
    model_reset();
    v0 = 1'b0; v1 = 1'b0;
    $display("test_reset complete");
  endtask

  task automatic test_single_requester();
    sel = 1'b0;
    for (int k = 0; k < 64; k++) begin
      va0[k] = 1'b1; va1[k] = 1'b0; sa[k] = 1'b0;
      da0[k] = (k == 2) ? 8'h11 : 8'h10; da1[k] = 8'($urandom);
    end
    run_session("single_req0");
  endtask

  task automatic test_round_robin();
    sel = 1'b1;
    for (int k = 0; k < 64; k++) begin
      va0[k] = 1'b1; va1[k] = 1'b1; sa[k] = 1'b0;
      da0[k] = 8'($urandom); da1[k] = 8'($urandom);
    end
    run_session("round_robin");
  endtask

  task automatic test_stop();
    sel = 1'b0;
    for (int k = 0; k < 64; k++) begin
      va0[k] = 1'b1; va1[k] = 1'b0; sa[k] = (k == 1);
      da0[k] = 8'($urandom); da1[k] = 8'($urandom);
    end
    run_session("stop_2nd_run");
  endtask

  task automatic test_reset_mid_run();
    sel = 1'b0;
    @(negedge sim_clk);
    start0 = 1'b1; v0 = 1'b1; v1 = 1'b0; stop_s = 1'b0; d0 = 8'h5A;
    @(negedge sim_clk);
    start0 = 1'b0;
    repeat (11) @(negedge sim_clk);
    #1;
    checks++;
    if (o_en !== 1'b1 || o_vt !== 16'd1) begin
      errors++;
      $display("FAIL mid_run_pre: got en=%b vt=%0d, required en=1 vt=1", o_en, o_vt);
    end
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_run");
    for (int i = 0; i < 3; i++) begin
      @(posedge sim_clk);
      #1;
      checks++;
      if (o_done !== 1'b0 || o_r0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got done=%b r0=%b, required 0 0", o_done, o_r0);
      end
    end
    @(negedge sim_clk);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 64; k++) begin
      va0[k] = 1'b1; va1[k] = 1'b1; sa[k] = 1'b0;
      da0[k] = 8'($urandom); da1[k] = 8'($urandom);
    end
    run_session("after_reset");
  endtask

  task automatic test_settle_zero();
    sel = 1'b1;
    for (int k = 0; k < 64; k++) begin
      va0[k] = 1'b0; va1[k] = 1'b1; sa[k] = 1'b0;
      da0[k] = 8'($urandom); da1[k] = 8'($urandom);
    end
    run_session("settle_zero_req1");
  endtask

  task automatic test_no_valid();
    sel = 1'b0;
    for (int k = 0; k < 64; k++) begin
      va0[k] = 1'b0; va1[k] = 1'b0; sa[k] = (k == 20);
      da0[k] = 8'($urandom); da1[k] = 8'($urandom);
    end
    run_session("idle_run");
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      sel = 1'(s % 2);
      for (int k = 0; k < 64; k++) begin
        va0[k] = 1'($urandom); va1[k] = 1'($urandom);
        sa[k] = ($urandom_range(0, 11) == 0) || (k == 63);
        da0[k] = 8'($urandom); da1[k] = 8'($urandom);
      end
      run_session($sformatf("random_%0d", s));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_requester();
    test_round_robin();
    test_stop();
    test_reset_mid_run();
    test_settle_zero();
    test_no_valid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_sched.md
SAMPLE_SCHED -- requirements
Module: sample_sched

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 10, meaning the number of idle cycles between start and the first grant.
REQ-002 The block SHALL have parameter MAX_VECTORS, default 3, meaning the number of accepted vectors per session (range 1..65535).
REQ-003 The block SHALL have port sim_clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset=0 resets the block immediately).
REQ-005 The block SHALL have port start, input, 1 bit: begins a session when sampled high in IDLE.
REQ-006 The block SHALL have port stop, input, 1 bit: aborts a running session.
REQ-007 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester has a vector.
REQ-008 The block SHALL have ports req0_data / req1_data, input, 8 bits each: requester vector.
REQ-009 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: vector accepted this cycle.
REQ-010 The block SHALL have port smp_data_in, output, 8 bits: data to the sample counter.
REQ-011 The block SHALL have port smp_enable, output, 1 bit: enable to the sample counter.
REQ-012 The block SHALL have port smp_count, input, 10 bits: count returned by the sample counter.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse at session end.
REQ-015 The block SHALL have port final_count, output, 10 bits: smp_count captured at session end.
REQ-016 The block SHALL have port vec_total, output, 16 bits: vectors accepted in the current or last session.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, SETTLE, RUN and DRAIN.
REQ-018 In IDLE, start=1 SHALL move the FSM to SETTLE, clear vec_total, and load the settle counter with SETTLE_CYCLES.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles with both readys low and smp_enable low; with SETTLE_CYCLES=0 the FSM SHALL go directly from IDLE to RUN.
REQ-020 A transfer SHALL occur on a rising edge where state=RUN, stop=0, and the granted reqN_valid=1; reqN_ready SHALL be combinational: (state==RUN) & ~stop & grant==N & reqN_valid.
REQ-021 Arbitration SHALL be round-robin: with a single valid request, that requester is granted; with both valid, the requester not granted last is granted; after reset the pointer SHALL favour req0.
REQ-022 At most one ready SHALL be high in any cycle.
REQ-023 On a transfer edge, the block SHALL register smp_enable<=1 and smp_data_in<=granted data, and increment vec_total; on any other edge smp_enable<=0 and smp_data_in SHALL hold its value.
REQ-024 The FSM SHALL move from RUN to DRAIN on the edge of the transfer that makes vec_total==MAX_VECTORS, or on any RUN edge with stop=1 (no transfer occurs on that edge).
REQ-025 DRAIN SHALL last exactly 2 cycles with both readys low; on the edge leaving DRAIN, final_count<=smp_count, done<=1 for one cycle, and the FSM SHALL go to IDLE.
REQ-026 start SHALL be ignored outside IDLE; stop SHALL be ignored outside RUN; start and stop both high in IDLE SHALL start a session.
REQ-027 vec_total SHALL saturate at 65535 and SHALL hold its value in IDLE until the next start.

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, smp_enable=0, smp_data_in=0, busy=0, done=0, final_count=0, vec_total=0, settle counter=0, and the round-robin pointer to favour req0.
REQ-029 Reset asserted mid-session SHALL abandon the session without a done pulse; readys SHALL be low while reset=0.
REQ-030 The first start after reset deassertion SHALL be honoured on the first rising edge at which reset=1.

Verification
REQ-031 Directed case: reset, start pulse, req0 only valid with data 8'h10, 8'h10, 8'h11 -> no ready for 10 cycles, then 3 consecutive req0_ready; smp_enable high 3 cycles; done pulse 2 cycles after the last transfer; vec_total=3; final_count equal to the counter model.
REQ-032 Directed case: both requesters valid continuously, MAX_VECTORS=4 -> grant order req0, req1, req0, req1; never both readys high.
REQ-033 Directed case: stop raised on the 2nd RUN cycle with req0 valid -> exactly 1 transfer; DRAIN then done; vec_total=1.
REQ-034 Directed case: reset pulled low during RUN after 1 transfer -> all outputs immediately 0; no done; next start runs a full session with the pointer favouring req0.
REQ-035 Directed case: SETTLE_CYCLES=0, start with req1 valid -> req1_ready high in the cycle after start; start re-pulsed while busy -> ignored (single done).
REQ-036 Directed case: no valid for 20 RUN cycles -> smp_enable stays 0; busy stays 1; vec_total stays 0.
